// File: rtl/fcc_edge_filter.sv
// Edge filter for the FCC clustering path. Pair tags ride alongside the distance unit's latency.
// Pairs with dist2 <= eps2 go into a credit-protected edge FIFO that feeds union-find.
module fcc_edge_filter #(
    parameter int IDXW  = 10,
    parameter int LAT   = 3,
    parameter int DEPTH = 16,
    parameter int DW    = 40
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [DW-1:0]   i_eps2,
    input  logic            i_frame_start,
    input  logic            i_frame_end,
    input  logic            i_issue_valid,
    input  logic [IDXW-1:0] i_issue_a,
    input  logic [IDXW-1:0] i_issue_b,
    output logic            o_issue_ready,
    input  logic [DW-1:0]   i_dist2,
    output logic            o_edge_valid,
    input  logic            i_edge_ready,
    output logic [IDXW-1:0] o_edge_a,
    output logic [IDXW-1:0] o_edge_b,
    output logic [15:0]     o_edge_count,
    output logic [23:0]     o_pair_count,
    output logic            o_busy,
    output logic            o_done
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int LCW = $clog2(LAT + 1);
    localparam int OW  = $clog2(DEPTH + LAT + 1);

    typedef struct packed {
        logic [IDXW-1:0] a;
        logic [IDXW-1:0] b;
    } pair_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [DW-1:0]     r_eps2;
    logic [LAT:1]      r_vld_pipe;
    pair_t [LAT:1]     r_tag_pipe;
    pair_t             r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic [23:0]       r_pair_cnt;
    logic [15:0]       r_edge_cnt;
    logic              r_busy, r_done;

    logic [LCW-1:0]    w_inflight;
    logic [OW-1:0]     w_occ;
    logic              w_issue_acc;
    logic              w_exit_v;
    pair_t             w_exit_tag;
    logic              w_push, w_pop;
    pair_t             w_head;

    always_comb begin
        w_inflight = '0;
        for (int i = 1; i <= LAT; i++) w_inflight = w_inflight + LCW'(r_vld_pipe[i]);
    end

    // Occupancy counts pairs still in the distance unit, so every accepted pair owns a FIFO slot.
    assign w_occ       = OW'(r_cnt) + OW'(w_inflight);
    assign w_issue_acc = i_issue_valid && o_issue_ready && !i_frame_start;

    assign w_exit_v   = r_vld_pipe[LAT];
    assign w_exit_tag = r_tag_pipe[LAT];
    assign w_push     = w_exit_v && !i_frame_start && (i_dist2 <= r_eps2) && (w_exit_tag.a != w_exit_tag.b);
    assign w_pop      = o_edge_valid && i_edge_ready && !i_frame_start;

    // FSM: frame_start wins from any state, including over a same-cycle frame_end.
    always_comb begin
        w_state_nxt   = r_state;
        o_issue_ready = 1'b0;
        if (r_state == S_RUN && w_occ < OW'(DEPTH)) o_issue_ready = 1'b1;
        if (i_frame_start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (i_frame_end) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_inflight == '0 && r_cnt == '0) w_state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (r_state == S_RUN) || (r_state == S_DRAIN);
            r_done  <= (r_state == S_DONE);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
        end else if (i_frame_start) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_issue_acc;
            r_tag_pipe[1] <= {i_issue_a, i_issue_b};
            for (int i = 2; i <= LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_exit_tag;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_eps2     <= '0;
            r_pair_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (i_frame_start) begin
            r_eps2     <= i_eps2;
            r_pair_cnt <= '0;
            r_edge_cnt <= '0;
        end else begin
            if (w_exit_v && r_pair_cnt != '1) r_pair_cnt <= r_pair_cnt + 1'b1;
            if (w_push && r_edge_cnt != '1)   r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    // Head data is masked so an empty FIFO never exposes stale or uninitialised storage.
    assign w_head       = r_mem[r_rd_ptr];
    assign o_edge_valid = (r_cnt != '0);
    assign o_edge_a     = o_edge_valid ? w_head.a : '0;
    assign o_edge_b     = o_edge_valid ? w_head.b : '0;
    assign o_edge_count = r_edge_cnt;
    assign o_pair_count = r_pair_cnt;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_fcc_edge_filter.sv
// Scenario bench for fcc_edge_filter: a distance-unit delay model drives dist2 and a queue
// scoreboard checks every popped edge in issue order.
module tb_fcc_edge_filter;
    localparam int IDXW  = 10;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;
    localparam int DW    = 40;

    typedef struct packed {
        logic [IDXW-1:0] a;
        logic [IDXW-1:0] b;
    } pair_t;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [DW-1:0]   i_eps2;
    logic            i_frame_start, i_frame_end, i_issue_valid, i_edge_ready;
    logic [IDXW-1:0] i_issue_a, i_issue_b;
    logic [DW-1:0]   i_dist2;
    logic            o_issue_ready, o_edge_valid, o_busy, o_done;
    logic [IDXW-1:0] o_edge_a, o_edge_b;
    logic [15:0]     o_edge_count;
    logic [23:0]     o_pair_count;
    logic [63:0]     w_all_out;

    int            n_checks = 0;
    int            n_fail   = 0;
    pair_t         exp_q[$];
    logic [DW-1:0] m_eps2;
    int            m_pairs, m_edges;
    logic [DW-1:0] tb_dist_in;
    logic [DW-1:0] dpipe [LAT];

    fcc_edge_filter #(.IDXW(IDXW), .LAT(LAT), .DEPTH(DEPTH), .DW(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_eps2(i_eps2),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_issue_valid(i_issue_valid), .i_issue_a(i_issue_a), .i_issue_b(i_issue_b),
        .o_issue_ready(o_issue_ready), .i_dist2(i_dist2),
        .o_edge_valid(o_edge_valid), .i_edge_ready(i_edge_ready),
        .o_edge_a(o_edge_a), .o_edge_b(o_edge_b),
        .o_edge_count(o_edge_count), .o_pair_count(o_pair_count),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    assign w_all_out = {o_issue_ready, o_edge_valid, o_edge_a, o_edge_b,
                        o_edge_count, o_pair_count, o_busy, o_done};

    // Distance-unit model: the value offered with an issue appears LAT cycles later.
    always @(posedge i_clk) begin
        dpipe[0] <= i_issue_valid ? tb_dist_in : '0;
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign i_dist2 = dpipe[LAT-1];

    // Scoreboard: every pop must match the oldest expected edge.
    always @(negedge i_clk) begin
        pair_t e;
        if (!i_rst && !i_frame_start && o_edge_valid && i_edge_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL edge_pop: got (%0d,%0d), required no edge", o_edge_a, o_edge_b);
            end else begin
                e = exp_q.pop_front();
                if ({o_edge_a, o_edge_b} !== e) begin
                    n_fail++;
                    $display("FAIL edge_pop: got (%0d,%0d), required (%0d,%0d)", o_edge_a, o_edge_b, e.a, e.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame(input logic [DW-1:0] eps);
        i_frame_start = 1'b1;
        i_eps2        = eps;
        m_eps2        = eps;
        m_pairs       = 0;
        m_edges       = 0;
        exp_q.delete();
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic model_accept(input int a, input int b, input logic [DW-1:0] d);
        m_pairs++;
        if (d <= m_eps2 && a != b) begin
            exp_q.push_back({IDXW'(a), IDXW'(b)});
            m_edges++;
        end
    endtask

    task automatic drive_pair(input int a, input int b, input logic [DW-1:0] d);
        i_issue_valid = 1'b1;
        i_issue_a     = IDXW'(a);
        i_issue_b     = IDXW'(b);
        tb_dist_in    = d;
    endtask

    task automatic issue(input int a, input int b, input logic [DW-1:0] d);
        drive_pair(a, b, d);
        model_accept(a, b, d);
        tick();
        i_issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_eps2 = '0; i_frame_start = 0; i_frame_end = 0;
        i_issue_valid = 0; i_issue_a = '0; i_issue_b = '0; i_edge_ready = 0; tb_dist_in = '0;
        #1;
        n_checks++;
        if (w_all_out !== 64'd0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", w_all_out); end
        repeat (2) tick();
        i_rst = 1'b0;
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
        tick();
        n_checks++;
        if (w_all_out !== 64'd0) begin n_fail++; $display("FAIL idle_frame_end: got %h, required 0", w_all_out); end
    endtask

    task automatic test_in_radius();
        start_frame(40'd100);
        i_eps2 = '0;
        i_edge_ready = 1'b0;
        issue(1, 2, 40'd100);
        repeat (4) tick();
        n_checks++;
        if ({o_edge_valid, o_edge_a, o_edge_b} !== {1'b1, 10'd1, 10'd2}) begin
            n_fail++; $display("FAIL inclusive_head: got v=%b (%0d,%0d), required v=1 (1,2)", o_edge_valid, o_edge_a, o_edge_b);
        end
        n_checks++;
        if ({o_edge_count, o_pair_count} !== {16'(m_edges), 24'(m_pairs)}) begin
            n_fail++; $display("FAIL inclusive_counts: got e=%0d p=%0d, required e=%0d p=%0d", o_edge_count, o_pair_count, m_edges, m_pairs);
        end
        n_checks++;
        if ({o_busy, o_done} !== 2'b10) begin
            n_fail++; $display("FAIL run_status: got busy=%b done=%b, required 1 0", o_busy, o_done);
        end
        i_edge_ready = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (o_edge_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL inclusive_drain: got v=%b left=%0d, required v=0 left=0", o_edge_valid, exp_q.size());
        end
    endtask

    task automatic test_out_of_radius();
        start_frame(40'd100);
        i_edge_ready = 1'b1;
        issue(1, 3, 40'd101);
        issue(5, 5, 40'd0);
        issue(6, 7, 40'd0);
        issue(2, 9, 40'hFF_FFFF_FFFF);
        repeat (6) tick();
        n_checks++;
        if ({o_edge_count, o_pair_count} !== {16'(m_edges), 24'(m_pairs)}) begin
            n_fail++; $display("FAIL outside_counts: got e=%0d p=%0d, required e=%0d p=%0d", o_edge_count, o_pair_count, m_edges, m_pairs);
        end
        start_frame(40'hFF_FFFF_FFFF);
        issue(3, 4, 40'hFF_FFFF_FFFF);
        repeat (6) tick();
        n_checks++;
        if ({o_edge_count, o_pair_count, o_edge_valid} !== {16'd1, 24'd1, 1'b0} || exp_q.size() != 0) begin
            n_fail++; $display("FAIL max_eps: got e=%0d p=%0d v=%b left=%0d, required e=1 p=1 v=0 left=0", o_edge_count, o_pair_count, o_edge_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int  idx = 0;
        int  occ = 0;
        int  guard = 0;
        logic exp_rdy;
        start_frame(40'd1000);
        i_edge_ready = 1'b0;
        for (int c = 0; c < 24; c++) begin
            exp_rdy = (occ < DEPTH);
            drive_pair(idx + 16, idx + 100, 40'(idx * 10));
            n_checks++;
            if (o_issue_ready !== exp_rdy) begin
                n_fail++; $display("FAIL credit_c%0d: got ready=%b, required %b", c, o_issue_ready, exp_rdy);
            end
            if (exp_rdy) begin
                model_accept(idx + 16, idx + 100, 40'(idx * 10));
                idx++;
                occ++;
            end
            tick();
        end
        n_checks++;
        if ({o_edge_count, o_pair_count, o_edge_valid} !== {16'd16, 24'd16, 1'b1}) begin
            n_fail++; $display("FAIL stall_store: got e=%0d p=%0d v=%b, required e=16 p=16 v=1", o_edge_count, o_pair_count, o_edge_valid);
        end
        i_edge_ready = 1'b1;
        tick();
        n_checks++;
        if (o_issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL credit_return: got ready=%b, required 1", o_issue_ready);
        end
        while (idx < 40 && guard < 200) begin
            drive_pair(idx + 16, idx + 100, 40'(idx * 10));
            if (o_issue_ready) begin
                model_accept(idx + 16, idx + 100, 40'(idx * 10));
                idx++;
            end
            tick();
            guard++;
        end
        i_issue_valid = 1'b0;
        n_checks++;
        if (guard >= 200) begin n_fail++; $display("FAIL b2b_issue_timeout: got %0d issued, required 40", idx); end
        repeat (24) tick();
        n_checks++;
        if ({o_edge_count, o_pair_count} !== {16'd40, 24'd40} || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_totals: got e=%0d p=%0d left=%0d, required e=40 p=40 left=0", o_edge_count, o_pair_count, exp_q.size());
        end
    endtask

    task automatic test_drain_done();
        int n = 0;
        start_frame(40'd50);
        i_edge_ready = 1'b0;
        issue(10, 11, 40'd1);
        issue(12, 13, 40'd2);
        issue(14, 15, 40'd50);
        repeat (4) tick();
        issue(16, 17, 40'd3);
        drive_pair(18, 19, 40'd4);
        model_accept(18, 19, 40'd4);
        i_frame_end  = 1'b1;
        i_edge_ready = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        i_frame_end   = 1'b0;
        n_checks++;
        if (o_issue_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b, required 0", o_issue_ready); end
        while (!o_done && n < 20) begin tick(); n++; end
        n_checks++;
        if (n >= 20) begin n_fail++; $display("FAIL done_timeout: got done=%b after %0d cycles, required 1", o_done, n); end
        n_checks++;
        if ({o_edge_count, o_pair_count, o_edge_valid, o_busy} !== {16'd5, 24'd5, 1'b0, 1'b0} || exp_q.size() != 0) begin
            n_fail++; $display("FAIL done_state: got e=%0d p=%0d v=%b busy=%b left=%0d, required e=5 p=5 v=0 busy=0 left=0",
                               o_edge_count, o_pair_count, o_edge_valid, o_busy, exp_q.size());
        end
        i_frame_end = 1'b1;
        tick();
        i_frame_end = 1'b0;
        tick();
        n_checks++;
        if ({o_done, o_issue_ready} !== 2'b10) begin
            n_fail++; $display("FAIL done_frame_end: got done=%b ready=%b, required 1 0", o_done, o_issue_ready);
        end
        start_frame(40'd50);
        tick();
        n_checks++;
        if ({o_done, o_busy, o_edge_count, o_pair_count} !== {1'b0, 1'b1, 16'd0, 24'd0}) begin
            n_fail++; $display("FAIL restart_from_done: got done=%b busy=%b e=%0d p=%0d, required 0 1 0 0", o_done, o_busy, o_edge_count, o_pair_count);
        end
    endtask

    task automatic test_frame_restart();
        start_frame(40'd500);
        i_edge_ready = 1'b0;
        issue(20, 21, 40'd5);
        issue(22, 23, 40'd5);
        i_frame_end = 1'b1;
        start_frame(40'd500);
        i_frame_end = 1'b0;
        repeat (5) tick();
        n_checks++;
        if ({o_edge_count, o_pair_count, o_edge_valid, o_issue_ready} !== {16'd0, 24'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL flush: got e=%0d p=%0d v=%b ready=%b, required 0 0 0 1", o_edge_count, o_pair_count, o_edge_valid, o_issue_ready);
        end
    endtask

    task automatic test_reset_midrun();
        start_frame(40'd100);
        i_edge_ready = 1'b0;
        issue(30, 31, 40'd7);
        issue(32, 33, 40'd8);
        repeat (4) tick();
        n_checks++;
        if (o_edge_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_fill: got v=%b, required 1", o_edge_valid); end
        #2 i_rst = 1'b1;
        #1;
        n_checks++;
        if (w_all_out !== 64'd0) begin n_fail++; $display("FAIL async_reset: got %h, required 0", w_all_out); end
        exp_q.delete();
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        n_checks++;
        if (w_all_out !== 64'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h, required 0", w_all_out); end
        i_edge_ready = 1'b1;
        start_frame(40'd100);
        issue(40, 41, 40'd9);
        repeat (6) tick();
        n_checks++;
        if ({o_edge_count, o_pair_count} !== {16'd1, 24'd1} || exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_restart: got e=%0d p=%0d left=%0d, required 1 1 0", o_edge_count, o_pair_count, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_in_radius();
        test_out_of_radius();
        test_back_to_back();
        test_drain_done();
        test_frame_restart();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
